// File: rtl/clkgen_ctrl.sv
// rtl/clkgen_ctrl.sv - programmable clock generator; optional period counter via CLKGEN_CTRL_PERIOD_CNT_EN
module clkgen_ctrl #(
    parameter int WIDTH      = 16,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
    ,
    output logic [31:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] per_r;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] pend_per;
    logic [WIDTH-1:0] pend_high;
    logic             pend;
    logic [WIDTH-1:0] cnt;

    logic             cfg_take;
    logic             cfg_legal;
    logic [WIDTH-1:0] low_len;
    logic             high_done;
    logic             boundary;

    // Only one configuration can wait for a period boundary at a time.
    assign cfg_ready = !pend;
    assign cfg_take  = cfg_valid && !pend;
    // high < period also rules out period 0/1 with a nonzero high time.
    assign cfg_legal = (cfg_period >= WIDTH'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign low_len   = per_r - high_r;
    assign high_done = (cnt == high_r - WIDTH'(1));
    // The last LOW cycle closes a period; new settings only take effect here.
    assign boundary  = (state == S_LOW) && (cnt == low_len - WIDTH'(1));
    assign busy      = (state != S_IDLE);

    // Phase sequencing, configuration handling and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            per_r      <= WIDTH'(DEF_PERIOD);
            high_r     <= WIDTH'(DEF_HIGH);
            pend_per   <= '0;
            pend_high  <= '0;
            pend       <= 1'b0;
            cnt        <= '0;
            cfg_err    <= 1'b0;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cfg_err    <= cfg_take && !cfg_legal;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            if (boundary && pend) begin
                per_r  <= pend_per;
                high_r <= pend_high;
                pend   <= 1'b0;
            end

            if (cfg_take && cfg_legal) begin
                if (state == S_IDLE) begin
                    per_r  <= cfg_period;
                    high_r <= cfg_high;
                end else begin
                    pend      <= 1'b1;
                    pend_per  <= cfg_period;
                    pend_high <= cfg_high;
                end
            end

            case (state)
                S_IDLE: begin
                    if (run) begin
                        state      <= S_HIGH;
                        cnt        <= '0;
                        clk_out    <= 1'b1;
                        rise_pulse <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (high_done) begin
                        state      <= S_LOW;
                        cnt        <= '0;
                        clk_out    <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                S_LOW: begin
                    if (boundary) begin
                        cnt <= '0;
                        if (run) begin
                            state      <= S_HIGH;
                            clk_out    <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
    // Counts completed periods, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (boundary) begin
            period_cnt <= period_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clkgen_ctrl.sv
// tb/tb_clkgen_ctrl.sv - self-checking bench for clkgen_ctrl
module tb_clkgen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_period = 16'd0;
    logic [15:0] cfg_high = 16'd0;
    logic        cfg_err;
    logic        clk_out;
    logic        rise_pulse;
    logic        fall_pulse;
    logic        busy;
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    clkgen_ctrl #(.WIDTH(16), .DEF_PERIOD(10), .DEF_HIGH(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: position inside the current period (-1 when idle) plus active/pending settings.
    int          m_pos = -1;
    int          m_per = 10;
    int          m_high = 7;
    int          m_pp = 0;
    int          m_ph = 0;
    bit          m_pend = 1'b0;
    bit          m_err = 1'b0;
    int unsigned m_pcnt = 0;
    bit          m_valid = 1'b0;
    bit          m_take, m_legal, m_bnd;

    always @(posedge clk) begin
        if (rst) begin
            m_pos   = -1;
            m_per   = 10;
            m_high  = 7;
            m_pend  = 1'b0;
            m_err   = 1'b0;
            m_pcnt  = 0;
            m_valid = 1'b1;
        end else begin
            m_take  = cfg_valid && !m_pend;
            m_legal = (int'(cfg_period) >= 2) && (int'(cfg_high) >= 1) &&
                      (int'(cfg_high) <= int'(cfg_period) - 1);
            m_err   = m_take && !m_legal;
            m_bnd   = (m_pos >= 0) && (m_pos == m_per - 1);
            if (m_bnd && m_pend) begin
                m_per  = m_pp;
                m_high = m_ph;
                m_pend = 1'b0;
            end
            if (m_take && m_legal) begin
                if (m_pos < 0) begin
                    m_per  = int'(cfg_period);
                    m_high = int'(cfg_high);
                end else begin
                    m_pend = 1'b1;
                    m_pp   = int'(cfg_period);
                    m_ph   = int'(cfg_high);
                end
            end
            if (m_pos < 0) begin
                if (run) m_pos = 0;
            end else if (m_bnd) begin
                m_pcnt++;
                m_pos = run ? 0 : -1;
            end else begin
                m_pos++;
            end
        end
    end

    // Every cycle after the first reset, all outputs must match the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("clk_out",    clk_out,    (m_pos >= 0) && (m_pos < m_high));
            chk("rise_pulse", rise_pulse, m_pos == 0);
            chk("fall_pulse", fall_pulse, (m_pos >= 0) && (m_pos == m_high));
            chk("busy",       busy,       m_pos >= 0);
            chk("cfg_ready",  cfg_ready,  !m_pend);
            chk("cfg_err",    cfg_err,    m_err);
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
            chk("period_cnt", period_cnt, m_pcnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int n, output int highs, output int rises, output int falls);
        highs = 0; rises = 0; falls = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            highs += int'(clk_out);
            rises += int'(rise_pulse);
            falls += int'(fall_pulse);
        end
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_ready",   cfg_ready, 1);
        chk("rst_busy",    busy, 0);
        tick();
        rst = 1'b0;
    endtask

    int hi, ri, fa;

    initial begin
        // Default 10/7 under continuous run.
        do_reset();
        run = 1'b1;
        tick();
        window(30, hi, ri, fa);
        chk("def_highs", hi, 21);
        chk("def_rises", ri, 3);
        chk("def_falls", fa, 3);
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
        chk("def_pcnt", period_cnt, 2);
`endif

        // 4/2 loaded while idle applies from the first period.
        do_reset();
        offer(4, 2);
        run = 1'b1;
        tick();
        tick();
        window(8, hi, ri, fa);
        chk("c42_highs", hi, 4);
        chk("c42_rises", ri, 2);

        // 6/1 offered mid-HIGH waits for the boundary.
        do_reset();
        run = 1'b1;
        tick();
        tick();
        offer(6, 1);
        window(8, hi, ri, fa);
        chk("mid_highs", hi, 5);
        chk("mid_rises", ri, 0);
        chk("mid_ready", cfg_ready, 0);
        window(6, hi, ri, fa);
        chk("new_highs", hi, 1);
        chk("new_rises", ri, 1);
        chk("new_falls", fa, 1);
        chk("new_ready", cfg_ready, 1);

        // Illegal offers are flagged and leave 10/7 in place.
        do_reset();
        offer(5, 5);
        @(negedge clk);
        chk("err_5_5", cfg_err, 1);
        tick();
        offer(1, 0);
        @(negedge clk);
        chk("err_1_0", cfg_err, 1);
        tick();
        offer(0, 0);
        @(negedge clk);
        chk("err_0_0", cfg_err, 1);
        tick();
        run = 1'b1;
        tick();
        window(10, hi, ri, fa);
        chk("err_highs", hi, 7);

        // run dropped early in HIGH still completes the period.
        do_reset();
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        window(9, hi, ri, fa);
        chk("drop_highs", hi, 6);
        chk("drop_falls", fa, 1);
        @(negedge clk);
        chk("drop_busy", busy, 0);
        chk("drop_clk_out", clk_out, 0);

        // Reset mid-LOW with a pending configuration restores defaults.
        do_reset();
        run = 1'b1;
        tick();
        offer(6, 1);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mr_clk_out", clk_out, 0);
        chk("mr_ready", cfg_ready, 1);
        chk("mr_busy", busy, 0);
`ifdef CLKGEN_CTRL_PERIOD_CNT_EN
        chk("mr_pcnt", period_cnt, 0);
`endif
        tick();
        rst = 1'b0;
        tick();
        window(10, hi, ri, fa);
        chk("mr_highs", hi, 7);
        chk("mr_rises", ri, 1);

        run = 1'b0;
        repeat (12) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clkgen_ctrl.md
CLKGEN_CTRL -- requirements
Module: clkgen_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the period and high-time fields.
REQ-002 SHALL have parameter DEF_PERIOD, default 10: period in clk cycles loaded at reset.
REQ-003 SHALL have parameter DEF_HIGH, default 7: high time in clk cycles loaded at reset (70% duty).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1: level request to generate clk_out.
REQ-007 SHALL have port cfg_valid, input, 1: a new configuration is offered.
REQ-008 SHALL have port cfg_ready, output, 1: the block can accept a configuration.
REQ-009 SHALL have port cfg_period, input, WIDTH: requested period in clk cycles.
REQ-010 SHALL have port cfg_high, input, WIDTH: requested high time in clk cycles.
REQ-011 SHALL have port cfg_err, output, 1: one-cycle pulse when an offered configuration is rejected.
REQ-012 SHALL have port clk_out, output, 1: generated clock, registered.
REQ-013 SHALL have port rise_pulse, output, 1: high in the first cycle of each high phase.
REQ-014 SHALL have port fall_pulse, output, 1: high in the first cycle of each low phase.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, HIGH and LOW; clk_out SHALL be 1 only in HIGH.
REQ-017 SHALL hold active registers per_r and high_r, plus pending registers pend_per, pend_high and flag pend.
REQ-018 SHALL accept a configuration on cfg_valid && cfg_ready; cfg_ready SHALL equal !pend.
REQ-019 SHALL treat a configuration as legal only if cfg_period >= 2 and 1 <= cfg_high <= cfg_period-1.
REQ-020 SHALL, for an illegal accepted offer, pulse cfg_err the next cycle and leave per_r, high_r and pend unchanged.
REQ-021 SHALL, for a legal offer accepted in IDLE, load per_r/high_r on the next edge with pend staying 0.
REQ-022 SHALL, for a legal offer accepted in HIGH/LOW, set pend and store the values for transfer at the next period boundary.
REQ-023 SHALL treat the last LOW cycle as the period boundary: there, load pend values into per_r/high_r and clear pend.
REQ-024 SHALL apply an offer accepted on the boundary cycle itself at the following boundary, never mid-period.
REQ-025 SHALL move IDLE -> HIGH one cycle after run is sampled 1: clk_out=1 and rise_pulse=1 on that same edge.
REQ-026 SHALL stay in HIGH for exactly high_r cycles, then enter LOW with fall_pulse=1.
REQ-027 SHALL stay in LOW for exactly per_r-high_r cycles.
REQ-028 SHALL, at the boundary, go to HIGH if run=1, else to IDLE.
REQ-029 SHALL never truncate a phase: deasserting run mid-period completes the current period, so clk_out is glitch-free.
REQ-030 SHALL continue seamlessly if run is reasserted before the boundary.
REQ-031 SHALL use an internal phase counter of WIDTH bits that never wraps given legal configurations.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, enter IDLE with per_r=DEF_PERIOD, high_r=DEF_HIGH and pend=0.
REQ-033 SHALL, on the same reset edge, drive clk_out=0, rise_pulse=0, fall_pulse=0, cfg_err=0, busy=0 and cfg_ready=1.
REQ-034 SHALL honour reset mid-period: clk_out drops at that edge and pending configuration is discarded.
REQ-035 SHALL give rst priority over run and cfg_valid in the same cycle.

Configuration
REQ-036 SHALL, with macro CLKGEN_CTRL_PERIOD_CNT_EN defined, add output period_cnt [31:0].
REQ-037 SHALL define period_cnt as reset to 0, incremented at each completed boundary, wrapping 0xFFFFFFFF -> 0.
REQ-038 SHALL, without CLKGEN_CTRL_PERIOD_CNT_EN, omit the port and counter; all other behaviour is identical.

Verification
REQ-039 SHALL cover: reset, run=1 held -> clk_out repeats 7 high / 3 low; rise_pulse every 10 cycles.
REQ-040 SHALL cover: in IDLE, cfg 4/2 accepted, then run=1 -> clk_out 2 high / 2 low from the first period.
REQ-041 SHALL cover: cfg 6/1 offered mid-HIGH of a 10/7 period -> current period stays 7/3, next is 1/5, cfg_ready=0 until the boundary.
REQ-042 SHALL cover: offers 5/5, 1/0 and 0/0 -> cfg_err pulses once each; period unchanged.
REQ-043 SHALL cover: run drops in cycle 2 of HIGH -> full 7/3 period completes, then IDLE, busy=0.
REQ-044 SHALL cover: rst mid-LOW with pend set -> clk_out=0 next edge, cfg 10/7 restored, period_cnt=0 when the macro is defined.
